// File: rtl/cla_byte_stream_sequencer.sv
// Byte-serial sequencer for an external 8-bit carry-lookahead adder.
// Feeds operand bytes (LSB first) and the chained carry to the adder
// combinationally, then registers the adder result into a single-entry
// output stage with valid/ready handshaking on both sides.
module cla_byte_stream_sequencer #(
  parameter int unsigned MAX_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_last,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_cout,
  output logic       out_last,
  output logic       out_ovf,
  output logic       out_trunc,
  output logic [7:0] word_count
);

  // Index of the last permitted byte in a word.
  localparam logic [7:0] LAST_IDX = 8'(MAX_BYTES - 1);

  logic       acc;
  logic       at_max;
  logic       word_end;

  logic       carry_q,      carry_d;
  logic [7:0] idx_q,        idx_d;
  logic       out_valid_q,  out_valid_d;
  logic [7:0] out_sum_q,    out_sum_d;
  logic       out_cout_q,   out_cout_d;
  logic       out_last_q,   out_last_d;
  logic       out_ovf_q,    out_ovf_d;
  logic       out_trunc_q,  out_trunc_d;
  logic [7:0] word_count_q, word_count_d;

  // Handshake, word-end detection and adder drive.
  always_comb begin
    in_ready = ~out_valid_q | out_ready;
    acc      = in_valid & in_ready;
    at_max   = (idx_q == LAST_IDX);
    word_end = in_last | at_max;
    add_a    = in_a;
    add_b    = in_b;
    add_cin  = carry_q;
  end

  // Next-state for carry chain, byte index, output stage and word counter.
  always_comb begin
    carry_d      = carry_q;
    idx_d        = idx_q;
    out_sum_d    = out_sum_q;
    out_cout_d   = out_cout_q;
    out_last_d   = out_last_q;
    out_ovf_d    = out_ovf_q;
    out_trunc_d  = out_trunc_q;
    word_count_d = word_count_q;
    out_valid_d  = out_valid_q;

    if (acc) begin
      carry_d     = word_end ? 1'b0 : add_cout;
      idx_d       = word_end ? '0 : idx_q + 8'd1;
      out_sum_d   = add_sum;
      out_cout_d  = add_cout;
      out_last_d  = word_end;
      out_trunc_d = at_max & ~in_last;
      out_ovf_d   = word_end & (in_a[7] ~^ in_b[7]) & (add_sum[7] ^ in_a[7]);
      out_valid_d = 1'b1;
      if (word_end) word_count_d = word_count_q + 8'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q      <= 1'b0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_cout_q   <= 1'b0;
      out_last_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_trunc_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_cout_q   <= out_cout_d;
      out_last_q   <= out_last_d;
      out_ovf_q    <= out_ovf_d;
      out_trunc_q  <= out_trunc_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_cout   = out_cout_q;
  assign out_last   = out_last_q;
  assign out_ovf    = out_ovf_q;
  assign out_trunc  = out_trunc_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_cla_byte_stream_sequencer.sv
// Directed testbench for cla_byte_stream_sequencer with a behavioural
// 8-bit adder attached to the add_* ports.
module tb_cla_byte_stream_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       out_last;
  logic       out_ovf;
  logic       out_trunc;
  logic [7:0] word_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural adder standing in for the CLA.
  logic [8:0] add_full;
  always_comb begin
    add_full = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    add_sum  = add_full[7:0];
    add_cout = add_full[8];
  end

  cla_byte_stream_sequencer #(.MAX_BYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout),
    .out_last   (out_last),
    .out_ovf    (out_ovf),
    .out_trunc  (out_trunc),
    .word_count (word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_last  = l;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic c,
                         input logic l, input logic o, input logic t);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".cout"},  32'(out_cout),  32'(c));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".ovf"},   32'(out_ovf),   32'(o));
    chk({tag, ".trunc"}, 32'(out_trunc), 32'(t));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.sum",   32'(out_sum),   32'd0);
    chk("rst.wc",    32'(word_count), 32'd0);
    chk("rst.ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Single-byte word with signed overflow.
    drive(1'b1, 8'h7F, 8'h01, 1'b1);
    chk("b1.cin", 32'(add_cin), 32'd0);
    chk("b1.adda", 32'(add_a), 32'h7F);
    step();
    chk_out("b1", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b1.wc", 32'(word_count), 32'd1);

    // Two-byte word 01FF + 0001.
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    chk_out("w2b0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 8'h00, 1'b1);
    chk("w2b1.cin", 32'(add_cin), 32'd1);
    step();
    chk_out("w2b1", 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("w2.wc", 32'(word_count), 32'd2);
    drive(1'b1, 8'h10, 8'h20, 1'b1);
    chk("w3.cin", 32'(add_cin), 32'd0);
    step();
    chk_out("w3", 8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("w3.wc", 32'(word_count), 32'd3);

    // Backpressure after the first byte of a two-byte word.
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    chk_out("bp0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp.ready", 32'(in_ready), 32'd0);
      chk("bp.cin",   32'(add_cin),  32'd1);
      step();
      chk("bp.sum",   32'(out_sum),  32'h00);
      chk("bp.valid", 32'(out_valid), 32'd1);
      chk("bp.wc",    32'(word_count), 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", 32'(in_ready), 32'd1);
    step();
    chk_out("bp1", 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp.wc2", 32'(word_count), 32'd4);

    // Truncation: five FF+01 bytes with no in_last.
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    chk_out("tr0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("tr1", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("tr2", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("tr3", 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("tr.wc", 32'(word_count), 32'd5);
    chk("tr4.cin", 32'(add_cin), 32'd0);
    step();
    chk_out("tr4", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tr4.cinnext", 32'(add_cin), 32'd1);

    // Reset mid-word discards the pending carry.
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    chk("mr.valid", 32'(out_valid), 32'd0);
    chk("mr.sum",   32'(out_sum),   32'd0);
    chk("mr.cout",  32'(out_cout),  32'd0);
    chk("mr.last",  32'(out_last),  32'd0);
    chk("mr.trunc", 32'(out_trunc), 32'd0);
    chk("mr.wc",    32'(word_count), 32'd0);
    chk("mr.cin",   32'(add_cin),   32'd0);
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 8'h00, 1'b1);
    chk("mr1.cin", 32'(add_cin), 32'd0);
    step();
    chk_out("mr1", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mr1.wc", 32'(word_count), 32'd1);

    // in_last without in_valid is ignored; output drains.
    drive(1'b0, 8'h55, 8'h55, 1'b1);
    step();
    chk("idle.valid", 32'(out_valid), 32'd0);
    chk("idle.wc",    32'(word_count), 32'd1);

    // 256 back-to-back single-byte words wrap the counter.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 8'h03, 1'b1);
      chk("wrap.ready", 32'(in_ready), 32'd1);
      step();
      chk("wrap.sum", 32'(out_sum), 32'((i + 3) & 8'hFF));
    end
    chk("wrap.wc", 32'(word_count), 32'd0);
    chk("wrap.valid", 32'(out_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_byte_stream_sequencer.md
# cla_byte_stream_sequencer

Byte-serial sequencer that feeds the 8-bit carry-lookahead adder and consumes its result, chaining carries across bytes so multi-byte operands are added one byte per cycle, least-significant byte first. It sits between the operand source (valid/ready byte stream) and the result sink. It drives the adder's operand and carry-in inputs combinationally, and registers the adder's sum and carry-out into a single-entry output stage.

## Interface
Parameters:
- MAX_BYTES, 4: maximum bytes per word; range 1..255.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- in_valid  input  1  operand byte pair present.
- in_ready  output  1  block accepts the pair this cycle.
- in_a  input  8  operand A byte.
- in_b  input  8  operand B byte.
- in_last  input  1  final (most-significant) byte of the word.
- add_a  output  8  to adder A; equals in_a.
- add_b  output  8  to adder B; equals in_b.
- add_cin  output  1  to adder carry-in; equals carry register.
- add_sum  input  8  from adder, combinational.
- add_cout  input  1  from adder, combinational.
- out_valid  output  1  result byte present.
- out_ready  input  1  sink accepts the result.
- out_sum  output  8  result byte.
- out_cout  output  1  carry out of this byte.
- out_last  output  1  final byte of the word.
- out_ovf  output  1  signed overflow; valid only when out_last=1, else 0.
- out_trunc  output  1  word was forced to end at MAX_BYTES.
- word_count  output  8  completed words, wraps 255→0.

## Operation
- Accept: acc = in_valid & in_ready.
- Ready rule: in_ready = ~out_valid | out_ready. This is a single-stage pipeline with full throughput.
- Carry register `carry`:
  - 0 at reset.
  - On acc with word end: carry ← 0.
  - On acc otherwise: carry ← add_cout.
- Byte counter `idx`, 8 bits:
  - 0 at reset.
  - On acc: idx ← 0 at word end, else idx+1.
- Word end = in_last | (idx == MAX_BYTES-1).
- Output register on acc:
  - out_sum ← add_sum.
  - out_cout ← add_cout.
  - out_last ← word end.
  - out_trunc ← (idx == MAX_BYTES-1) & ~in_last.
  - out_ovf ← word end & (in_a[7] ~^ in_b[7]) & (add_sum[7] ^ in_a[7]).
- out_valid:
  - Set on acc.
  - Cleared when out_ready & ~acc.
  - Held otherwise. Data holds stable while out_valid & ~out_ready.
- word_count increments on acc & word end.
- add_a, add_b and add_cin are driven every cycle, even when not accepting. The adder is purely combinational.

## Timing
- Reset (synchronous, rst_n=0 at a clk edge) clears: out_valid, out_sum, out_cout, out_last, out_ovf, out_trunc, carry, idx and word_count, all to 0.
- in_ready is combinational from out_valid and out_ready; it is 1 during and after reset.
- Latency: a byte accepted at edge N appears on out_* with out_valid=1 after edge N; the sink sees it in cycle N+1.
- Throughput: one byte per cycle while out_ready=1.
- Simultaneous out_ready and acc in the same cycle: the old result is consumed, the new one is loaded, and out_valid stays 1.
- Backpressure: out_valid=1 and out_ready=0 → in_ready=0, and carry/idx hold.
- Reset mid-word discards the partial word and its carry. The next accepted byte starts a new word with add_cin=0.
- MAX_BYTES=1: every byte is a word end, and add_cin is always 0.
- in_* are sampled only on acc. in_last while in_valid=0 is ignored.

## Test plan
- Single byte, 8'h7F + 8'h01, in_last=1, out_ready=1 → next cycle: out_sum=8'h80, out_cout=0, out_ovf=1, out_last=1, word_count=1.
- Two-byte word 16'h01FF + 16'h0001 (bytes FF+01, then 01+00 last):
  - Byte 0 → out_sum=00, out_cout=1.
  - Byte 1 → add_cin=1, out_sum=02, out_cout=0, out_last=1.
  - Next word's first byte → add_cin=0.
- Backpressure: hold out_ready=0 for 3 cycles after the first result.
  - in_ready=0 throughout; out_sum stays stable; the carry is not advanced.
  - Releasing out_ready → the second byte is accepted that same cycle and no byte is lost.
- Truncation with MAX_BYTES=4: send 5 bytes FF+01 with in_last=0.
  - Byte 4 → out_last=1, out_trunc=1.
  - Byte 5 → add_cin=0, idx restarts at 0.
- Reset mid-word: after byte 0 of FF+01 (carry=1), pulse rst_n=0 for one edge.
  - All outputs read 0.
  - Next byte 00+00 with in_last → out_sum=00, out_cout=0, word_count=1.
- Word counter wrap: 256 single-byte words → word_count returns to 0 and the back-to-back stream runs at full rate with out_ready=1.
